// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing source for the Arkanoid display.
// Produces 800x600@60 Hz counters, sync, blanking and a once-per-frame
// frame_start pulse. Every output is registered from the next-state counter
// values, so all outputs in a given cycle describe the same pixel.
module vga_timing_gen #(
  parameter int   H_VISIBLE = 800,
  parameter int   H_FRONT   = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BACK    = 88,
  parameter int   V_VISIBLE = 600,
  parameter int   V_FRONT   = 1,
  parameter int   V_SYNC    = 4,
  parameter int   V_BACK    = 23,
  parameter logic SYNC_POL  = 1'b1
) (
  input  logic        pclk,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start
);

  // Thresholds as 11-bit unsigned constants; every parameter sum must stay
  // below 2048 so the counters never overflow.
  localparam logic [10:0] H_LAST       = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] H_BLANK_FROM = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_FROM  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_TO    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_LAST       = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] V_BLANK_FROM = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_FROM  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_TO    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] hcount_nxt;
  logic [10:0] vcount_nxt;

  // Next raster position: h wraps at the end of a line, v steps only on that wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    hcount_nxt = hcount + 11'd1;
    vcount_nxt = vcount;
    if (hcount == H_LAST) begin
      hcount_nxt = '0;
      vcount_nxt = (vcount == V_LAST) ? '0 : vcount + 11'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge pclk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= hcount_nxt;
      vcount <= vcount_nxt;
    end
  end

  // Decodes taken from the next-state counters so they line up with hcount/vcount.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      hblnk       <= (hcount_nxt >= H_BLANK_FROM);
      vblnk       <= (vcount_nxt >= V_BLANK_FROM);
      hsync       <= ((hcount_nxt >= H_SYNC_FROM) && (hcount_nxt < H_SYNC_TO)) ? SYNC_POL : ~SYNC_POL;
      vsync       <= ((vcount_nxt >= V_SYNC_FROM) && (vcount_nxt < V_SYNC_TO)) ? SYNC_POL : ~SYNC_POL;
      // Reset parks the counters at (0,0) with this flag low, so the first
      // pulse only appears once the raster comes back around.
      frame_start <= (hcount_nxt == '0) && (vcount_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen.
// m_* = default 800x600 instance, s_* = small raster (25x16, active-high sync),
// n_* = same small raster with active-low sync. All share pclk and reset.
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int passed = 0;

  always #5 pclk = ~pclk;

  logic [10:0] m_hcount, m_vcount, s_hcount, s_vcount, n_hcount, n_vcount;
  logic m_hsync, m_hblnk, m_vsync, m_vblnk, m_fs;
  logic s_hsync, s_hblnk, s_vsync, s_vblnk, s_fs;
  logic n_hsync, n_hblnk, n_vsync, n_vblnk, n_fs;

  vga_timing_gen dut_m (
    .pclk(pclk), .reset(reset), .hcount(m_hcount), .hsync(m_hsync), .hblnk(m_hblnk),
    .vcount(m_vcount), .vsync(m_vsync), .vblnk(m_vblnk), .frame_start(m_fs)
  );

  // Small raster: h 16+2+4+3 = 25 (sync 18..21), v 10+1+2+3 = 16 (sync lines 11..12).
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b1)
  ) dut_s (
    .pclk(pclk), .reset(reset), .hcount(s_hcount), .hsync(s_hsync), .hblnk(s_hblnk),
    .vcount(s_vcount), .vsync(s_vsync), .vblnk(s_vblnk), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
  ) dut_n (
    .pclk(pclk), .reset(reset), .hcount(n_hcount), .hsync(n_hsync), .hblnk(n_hblnk),
    .vcount(n_vcount), .vsync(n_vsync), .vblnk(n_vblnk), .frame_start(n_fs)
  );

  // Bounded wait for the main instance to reach (h,v), sampled on negedges.
  task automatic wait_m(input logic [10:0] h, input logic [10:0] v);
    int n = 0;
    while (!(m_hcount == h && m_vcount == v) && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    total++;
    if (m_hcount !== h || m_vcount !== v)
      $display("FAIL wait_m: got (%0d,%0d) expected (%0d,%0d)", m_hcount, m_vcount, h, v);
    else passed++;
  endtask

  // Bounded wait for the small instances to reach (h,v).
  task automatic wait_s(input logic [10:0] h, input logic [10:0] v);
    int n = 0;
    while (!(s_hcount == h && s_vcount == v) && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    total++;
    if (s_hcount !== h || s_vcount !== v)
      $display("FAIL wait_s: got (%0d,%0d) expected (%0d,%0d)", s_hcount, s_vcount, h, v);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (10) @(negedge pclk);
    total++; if (m_hcount !== 11'd0) $display("FAIL rst_hcount: got %0d expected 0", m_hcount); else passed++;
    total++; if (m_vcount !== 11'd0) $display("FAIL rst_vcount: got %0d expected 0", m_vcount); else passed++;
    total++; if ({m_hblnk, m_vblnk, m_fs} !== 3'b000) $display("FAIL rst_blnk_fs: got %b expected 000", {m_hblnk, m_vblnk, m_fs}); else passed++;
    total++; if ({m_hsync, m_vsync} !== 2'b00) $display("FAIL rst_sync_pos: got %b expected 00", {m_hsync, m_vsync}); else passed++;
    total++; if ({n_hsync, n_vsync} !== 2'b11) $display("FAIL rst_sync_neg: got %b expected 11", {n_hsync, n_vsync}); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_count_start();
    for (int i = 1; i <= 5; i++) begin
      @(negedge pclk);
      total++;
      if (m_hcount !== 11'(i) || m_vcount !== 11'd0)
        $display("FAIL count_start: got (%0d,%0d) expected (%0d,0)", m_hcount, m_vcount, i);
      else passed++;
    end
  endtask

  task automatic test_line();
    wait_m(11'd799, 11'd0);
    total++; if (m_hblnk !== 1'b0) $display("FAIL hblnk_799: got %b expected 0", m_hblnk); else passed++;
    @(negedge pclk);
    total++; if (m_hblnk !== 1'b1) $display("FAIL hblnk_800: got %b expected 1", m_hblnk); else passed++;
    wait_m(11'd839, 11'd0);
    total++; if (m_hsync !== 1'b0) $display("FAIL hsync_839: got %b expected 0", m_hsync); else passed++;
    @(negedge pclk);
    total++; if (m_hsync !== 1'b1) $display("FAIL hsync_840: got %b expected 1", m_hsync); else passed++;
    wait_m(11'd967, 11'd0);
    total++; if (m_hsync !== 1'b1) $display("FAIL hsync_967: got %b expected 1", m_hsync); else passed++;
    @(negedge pclk);
    total++; if (m_hsync !== 1'b0 || m_hcount !== 11'd968) $display("FAIL hsync_968: got %b@%0d expected 0@968", m_hsync, m_hcount); else passed++;
    wait_m(11'd1055, 11'd0);
    total++; if (m_hblnk !== 1'b1) $display("FAIL hblnk_1055: got %b expected 1", m_hblnk); else passed++;
    @(negedge pclk);
    total++;
    if (m_hcount !== 11'd0 || m_vcount !== 11'd1 || m_hblnk !== 1'b0 || m_vblnk !== 1'b0 || m_fs !== 1'b0)
      $display("FAIL line_wrap: got h=%0d v=%0d hblnk=%b vblnk=%b fs=%b expected h=0 v=1 hblnk=0 vblnk=0 fs=0",
               m_hcount, m_vcount, m_hblnk, m_vblnk, m_fs);
    else passed++;
  endtask

  // One full small frame: interval between pulses plus per-output high/low counts.
  task automatic test_frame();
    int n = 0;
    int vs = 0, vb = 0, hs = 0, hb = 0, nhs = 0, nvs = 0, nvb = 0, nhb = 0;
    while (s_fs !== 1'b1 && n < 1000) begin @(negedge pclk); n++; end
    total++; if (s_fs !== 1'b1) $display("FAIL frame_sync: got fs=%b expected 1", s_fs); else passed++;
    n = 0;
    do begin
      vs += int'(s_vsync); vb += int'(s_vblnk); hs += int'(s_hsync); hb += int'(s_hblnk);
      nvs += int'(!n_vsync); nhs += int'(!n_hsync); nvb += int'(n_vblnk); nhb += int'(n_hblnk);
      @(negedge pclk);
      n++;
    end while (s_fs !== 1'b1 && n < 1000);
    total++; if (n !== 400) $display("FAIL frame_interval: got %0d expected 400", n); else passed++;
    total++; if (vs !== 50) $display("FAIL vsync_cycles: got %0d expected 50", vs); else passed++;
    total++; if (vb !== 150) $display("FAIL vblnk_cycles: got %0d expected 150", vb); else passed++;
    total++; if (hs !== 64) $display("FAIL hsync_cycles: got %0d expected 64", hs); else passed++;
    total++; if (hb !== 144) $display("FAIL hblnk_cycles: got %0d expected 144", hb); else passed++;
    total++; if (nvs !== 50 || nhs !== 64) $display("FAIL neg_sync_low_cycles: got v=%0d h=%0d expected v=50 h=64", nvs, nhs); else passed++;
    total++; if (nvb !== 150 || nhb !== 144) $display("FAIL neg_blnk_cycles: got v=%0d h=%0d expected v=150 h=144", nvb, nhb); else passed++;
  endtask

  task automatic test_corner();
    wait_s(11'd24, 11'd15);
    total++; if ({s_hblnk, s_vblnk, s_fs} !== 3'b110) $display("FAIL corner_pre: got %b expected 110", {s_hblnk, s_vblnk, s_fs}); else passed++;
    @(negedge pclk);
    total++;
    if (s_hcount !== 11'd0 || s_vcount !== 11'd0 || {s_hblnk, s_vblnk, s_fs} !== 3'b001)
      $display("FAIL corner_wrap: got h=%0d v=%0d hb/vb/fs=%b expected h=0 v=0 hb/vb/fs=001",
               s_hcount, s_vcount, {s_hblnk, s_vblnk, s_fs});
    else passed++;
    @(negedge pclk);
    total++; if (s_fs !== 1'b0 || s_hcount !== 11'd1) $display("FAIL corner_post: got fs=%b h=%0d expected fs=0 h=1", s_fs, s_hcount); else passed++;
  endtask

  // Edge points of the active-low sync instance.
  task automatic test_sync_pol0();
    wait_s(11'd17, 11'd0);
    total++; if (n_hsync !== 1'b1) $display("FAIL neg_hsync_17: got %b expected 1", n_hsync); else passed++;
    @(negedge pclk);
    total++; if (n_hsync !== 1'b0) $display("FAIL neg_hsync_18: got %b expected 0", n_hsync); else passed++;
    wait_s(11'd22, 11'd0);
    total++; if (n_hsync !== 1'b1) $display("FAIL neg_hsync_22: got %b expected 1", n_hsync); else passed++;
    wait_s(11'd24, 11'd10);
    total++; if (n_vsync !== 1'b1) $display("FAIL neg_vsync_l10: got %b expected 1", n_vsync); else passed++;
    @(negedge pclk);
    total++; if (n_vsync !== 1'b0 || n_vblnk !== 1'b1) $display("FAIL neg_vsync_l11: got vs=%b vb=%b expected vs=0 vb=1", n_vsync, n_vblnk); else passed++;
    wait_s(11'd0, 11'd13);
    total++; if (n_vsync !== 1'b1) $display("FAIL neg_vsync_l13: got %b expected 1", n_vsync); else passed++;
  endtask

  task automatic test_async_reset();
    int n;
    wait_s(11'd20, 11'd12);
    total++; if ({s_hblnk, s_vblnk, s_hsync, s_vsync} !== 4'b1111) $display("FAIL mid_pre: got %b expected 1111", {s_hblnk, s_vblnk, s_hsync, s_vsync}); else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if (s_hcount !== 11'd0 || s_vcount !== 11'd0 || {s_hblnk, s_vblnk, s_hsync, s_vsync, s_fs} !== 5'b00000)
      $display("FAIL async_rst_s: got h=%0d v=%0d flags=%b expected h=0 v=0 flags=00000",
               s_hcount, s_vcount, {s_hblnk, s_vblnk, s_hsync, s_vsync, s_fs});
    else passed++;
    total++; if (m_hcount !== 11'd0 || m_vcount !== 11'd0) $display("FAIL async_rst_m: got (%0d,%0d) expected (0,0)", m_hcount, m_vcount); else passed++;
    total++; if ({n_hsync, n_vsync} !== 2'b11) $display("FAIL async_rst_n: got %b expected 11", {n_hsync, n_vsync}); else passed++;
    @(negedge pclk);
    total++; if (s_hcount !== 11'd0) $display("FAIL rst_hold: got %0d expected 0", s_hcount); else passed++;
    reset = 1'b1;
    @(negedge pclk);
    n = 1;
    total++;
    if (s_hcount !== 11'd1 || s_vcount !== 11'd0 || m_hcount !== 11'd1 || s_fs !== 1'b0)
      $display("FAIL resume: got s=(%0d,%0d) m_h=%0d fs=%b expected s=(1,0) m_h=1 fs=0", s_hcount, s_vcount, m_hcount, s_fs);
    else passed++;
    while (s_fs !== 1'b1 && n < 1000) begin @(negedge pclk); n++; end
    total++; if (n !== 400) $display("FAIL first_pulse: got %0d expected 400", n); else passed++;
  endtask

  initial begin
    test_reset();
    test_count_start();
    test_line();
    test_frame();
    test_corner();
    test_sync_pol0();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
